// File: rtl/sky130_sram_1rw1r_gen.sv
// Behavioural 1RW + 1R SRAM with zero-fill on reset, byte-lane write mask and collision flag.
// Define SRAM_GEN_BYPASS_EN to forward port 0 write data to a colliding port 1 read (write-first).
module sky130_sram_1rw1r_gen #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int unsigned WMASK_GRAN = 8,
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  init_busy,
    output logic                  collision
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  fill_en;
    logic                  ports_en;
    logic [ADDR_WIDTH-1:0] init_ptr;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  valid0;
    logic                  valid1;
    logic                  rd0_req;
    logic                  wr0_req;
    logic                  rd1_req;
    logic                  wr0_en;
    logic                  hit;
    logic [DATA_WIDTH-1:0] rd0_word;
    logic [DATA_WIDTH-1:0] rd1_word;
    logic [DATA_WIDTH-1:0] rd1_data;

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_ptr == LAST_PTR) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        init_busy = 1'b0;
        fill_en   = 1'b0;
        ports_en  = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                fill_en   = 1'b1;
            end
            READY:   ports_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            init_ptr <= '0;
        end else if (fill_en) begin
            init_ptr <= init_ptr + 1'b1;
        end
    end

    // Addresses beyond RAM_DEPTH are decoded as invalid: writes dropped, reads return zero.
    always_comb begin
        valid0   = {1'b0, addr0} < DEPTH_EXT;
        valid1   = {1'b0, addr1} < DEPTH_EXT;
        rd0_req  = ports_en & ~csb0 & web0;
        wr0_req  = ports_en & ~csb0 & ~web0;
        rd1_req  = ports_en & ~csb1;
        wr0_en   = wr0_req & valid0;
        hit      = wr0_en & (|wmask0) & rd1_req & valid1 & (addr0 == addr1);
        rd0_word = valid0 ? mem[addr0] : '0;
        rd1_word = valid1 ? mem[addr1] : '0;
    end

`ifdef SRAM_GEN_BYPASS_EN
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = rd1_word;
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
                merged[i*WMASK_GRAN +: WMASK_GRAN] = din0[i*WMASK_GRAN +: WMASK_GRAN];
            end
        end
        rd1_data = hit ? merged : rd1_word;
    end
`else
    always_comb begin
        rd1_data = rd1_word;
    end
`endif

    always_ff @(posedge clk0) begin
        if (fill_en) begin
            mem[init_ptr] <= '0;
        end else if (wr0_en) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*WMASK_GRAN +: WMASK_GRAN] <= din0[i*WMASK_GRAN +: WMASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            dout0     <= '0;
            dout1     <= '0;
            collision <= 1'b0;
        end else if (!ports_en) begin
            dout0     <= '0;
            dout1     <= '0;
            collision <= 1'b0;
        end else begin
            if (rd0_req) dout0 <= rd0_word;
            if (rd1_req) dout1 <= rd1_data;
            collision <= hit;
        end
    end

endmodule

// File: tb/tb_sky130_sram_1rw1r_gen.sv
// Directed bench for sky130_sram_1rw1r_gen: default-depth instance plus a RAM_DEPTH=200 instance.
module tb_sky130_sram_1rw1r_gen;

    logic        clk0 = 1'b0;
    logic        rstb0;
    logic        csb0_a, csb1_a, csb0_b, csb1_b;
    logic        web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0;
    logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
    logic        busy_a, busy_b, coll_a, coll_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef SRAM_GEN_BYPASS_EN
    localparam logic [31:0] EXP_COLL = 32'h0102CCDD;
`else
    localparam logic [31:0] EXP_COLL = 32'h01020304;
`endif

    always #5 clk0 = ~clk0;

    sky130_sram_1rw1r_gen dut (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0_a), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_a), .csb1(csb1_a), .addr1(addr1),
        .dout1(dout1_a), .init_busy(busy_a), .collision(coll_a)
    );

    sky130_sram_1rw1r_gen #(.RAM_DEPTH(200)) dut200 (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0_b), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0_b), .csb1(csb1_b), .addr1(addr1),
        .dout1(dout1_b), .init_busy(busy_b), .collision(coll_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0_a = 1'b1; csb1_a = 1'b1; csb0_b = 1'b1; csb1_b = 1'b1;
        web0 = 1'b1; wmask0 = '0;
    endtask

    task automatic wr(input bit on_b, input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        if (on_b) csb0_b = 1'b0; else csb0_a = 1'b0;
        web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    task automatic rd0(input bit on_b, input logic [7:0] a);
        if (on_b) csb0_b = 1'b0; else csb0_a = 1'b0;
        web0 = 1'b1; addr0 = a;
    endtask

    task automatic rd1(input bit on_b, input logic [7:0] a);
        if (on_b) csb1_b = 1'b0; else csb1_a = 1'b0;
        addr1 = a;
    endtask

    // Runs until the default instance leaves INIT while hammering port requests that must be ignored.
    task automatic run_init(output int unsigned n_a, output int unsigned n_b, output logic leak);
        n_a = 0; n_b = 0; leak = 1'b0;
        idle();
        wr(1'b0, 8'h00, 32'hFFFF_FFFF, 4'hF);
        rd1(1'b0, 8'h00);
        while (busy_a && n_a < 1000) begin
            tick();
            n_a++;
            if (!busy_b && n_b == 0) n_b = n_a;
            if (dout0_a !== '0 || dout1_a !== '0 || coll_a !== 1'b0) leak = 1'b1;
        end
        idle();
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned na, nb;
        logic        lk;

        rstb0 = 1'b0; addr0 = '0; addr1 = '0; din0 = '0;
        idle();
        tick(); tick();
        check_eq("rst_dout0", dout0_a, 32'h0);
        check_eq("rst_dout1", dout1_a, 32'h0);
        check_eq("rst_coll", {31'b0, coll_a}, 32'h0);
        check_eq("rst_busy", {31'b0, busy_a}, 32'h1);

        rstb0 = 1'b1;
        run_init(na, nb, lk);
        check_eq("init_cycles_256", na, 32'd256);
        check_eq("init_cycles_200", nb, 32'd200);
        check_eq("init_ignored", {31'b0, lk}, 32'h0);
        check_eq("ready_busy", {31'b0, busy_a}, 32'h0);

        idle(); rd0(1'b0, 8'h00); rd1(1'b0, 8'hFF); tick();
        check_eq("zero_rd_00", dout0_a, 32'h0);
        check_eq("zero_rd_ff", dout1_a, 32'h0);

        idle(); wr(1'b0, 8'h12, 32'hDEAD_BEEF, 4'b1111); tick();
        check_eq("wr_hold_dout0", dout0_a, 32'h0);
        idle(); wr(1'b0, 8'h12, 32'h1122_3344, 4'b0101); tick();
        idle(); rd0(1'b0, 8'h12); tick();
        check_eq("mask_merge", dout0_a, 32'hDE22_BE44);

        idle(); wr(1'b0, 8'h40, 32'h0102_0304, 4'b1111); tick();
        check_eq("hold_on_write", dout0_a, 32'hDE22_BE44);
        idle(); tick();
        check_eq("hold_on_idle", dout0_a, 32'hDE22_BE44);

        idle(); wr(1'b0, 8'h40, 32'hAABB_CCDD, 4'b0011); rd1(1'b0, 8'h40); tick();
        check_eq("coll_pulse", {31'b0, coll_a}, 32'h1);
        check_eq("coll_dout1", dout1_a, EXP_COLL);
        idle(); tick();
        check_eq("coll_clear", {31'b0, coll_a}, 32'h0);
        check_eq("dout1_hold", dout1_a, EXP_COLL);
        idle(); rd0(1'b0, 8'h40); tick();
        check_eq("coll_wr_done", dout0_a, 32'h0102_CCDD);

        idle(); wr(1'b0, 8'h40, 32'hFFFF_FFFF, 4'b0000); rd1(1'b0, 8'h40); tick();
        check_eq("zmask_nocoll", {31'b0, coll_a}, 32'h0);
        check_eq("zmask_mem", dout1_a, 32'h0102_CCDD);

        idle(); rd0(1'b0, 8'h12); rd1(1'b0, 8'h12); tick();
        check_eq("dual_rd_dout0", dout0_a, 32'hDE22_BE44);
        check_eq("dual_rd_dout1", dout1_a, 32'hDE22_BE44);
        check_eq("dual_rd_nocoll", {31'b0, coll_a}, 32'h0);
        idle(); tick();
        check_eq("dual_hold_dout0", dout0_a, 32'hDE22_BE44);
        check_eq("dual_hold_dout1", dout1_a, 32'hDE22_BE44);

        idle(); wr(1'b0, 8'h13, 32'h5A5A_5A5A, 4'hF); rd1(1'b0, 8'h12); tick();
        check_eq("diff_addr_nocoll", {31'b0, coll_a}, 32'h0);
        check_eq("diff_addr_dout1", dout1_a, 32'hDE22_BE44);

        idle(); wr(1'b1, 8'h10, 32'h0000_0077, 4'hF); tick();
        idle(); rd0(1'b1, 8'h10); rd1(1'b1, 8'h10); tick();
        check_eq("d200_rd0", dout0_b, 32'h77);
        check_eq("d200_rd1", dout1_b, 32'h77);
        idle(); wr(1'b1, 8'hC7, 32'h0000_0099, 4'hF); tick();
        idle(); rd0(1'b1, 8'hC7); rd1(1'b1, 8'hC7); tick();
        check_eq("d200_last_rd0", dout0_b, 32'h99);
        check_eq("d200_last_rd1", dout1_b, 32'h99);
        idle(); wr(1'b1, 8'hF0, 32'h0000_0005, 4'hF); rd1(1'b1, 8'hF0); tick();
        check_eq("d200_oor_nocoll", {31'b0, coll_b}, 32'h0);
        check_eq("d200_oor_coll_rd", dout1_b, 32'h0);
        idle(); rd0(1'b1, 8'hF0); rd1(1'b1, 8'hF0); tick();
        check_eq("d200_oor_rd0", dout0_b, 32'h0);
        check_eq("d200_oor_rd1", dout1_b, 32'h0);

        idle(); wr(1'b0, 8'h41, 32'h1234_5678, 4'hF); rd1(1'b0, 8'h41); tick();
        check_eq("pre_rst_coll", {31'b0, coll_a}, 32'h1);
        idle();
        rstb0 = 1'b0;
        #1;
        check_eq("async_rst_dout0", dout0_a, 32'h0);
        check_eq("async_rst_dout1", dout1_a, 32'h0);
        check_eq("async_rst_coll", {31'b0, coll_a}, 32'h0);
        check_eq("async_rst_busy", {31'b0, busy_a}, 32'h1);
        tick();
        rstb0 = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check_eq("mid_init_busy", {31'b0, busy_a}, 32'h1);
        rstb0 = 1'b0;
        #1;
        check_eq("mid_init_rst_busy", {31'b0, busy_a}, 32'h1);
        tick();
        rstb0 = 1'b1;
        run_init(na, nb, lk);
        check_eq("reinit_cycles_256", na, 32'd256);
        check_eq("reinit_cycles_200", nb, 32'd200);
        check_eq("reinit_ignored", {31'b0, lk}, 32'h0);

        idle(); rd0(1'b0, 8'h12); rd1(1'b0, 8'h41); tick();
        check_eq("refill_12", dout0_a, 32'h0);
        check_eq("refill_41", dout1_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
